// File: rtl/ctrl_pkg.sv
// Shared types and default opcode encodings for the multi-cycle control sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_LDI,
    C_CMP,
    C_BRU,
    C_BRC,
    C_LD,
    C_ST,
    C_HALT
  } op_class_t;

  localparam int DEF_OPW = 3;
  localparam int DEF_IW  = 9;
  localparam int DEF_MEM_TIMEOUT = 16;

  localparam logic [2:0] DEF_OP_LDI  = 3'b000;
  localparam logic [2:0] DEF_OP_CMP  = 3'b010;
  localparam logic [2:0] DEF_OP_BRU  = 3'b011;
  localparam logic [2:0] DEF_OP_HALT = 3'b100;
  localparam logic [2:0] DEF_OP_BRC  = 3'b101;
  localparam logic [2:0] DEF_OP_LD   = 3'b110;
  localparam logic [2:0] DEF_OP_ST   = 3'b111;

  typedef struct packed {
    logic ir_load;
    logic pc_en;
    logic branch;
    logic ld_immed;
    logic mem_to_reg;
    logic mem_req;
    logic mem_write;
    logic reg_write;
  } ctrl_sig_t;

endpackage

// File: rtl/ctrl_op_class.sv
// Combinational opcode -> instruction class decoder; unlisted encodings are generic ALU ops.
module ctrl_op_class
  import ctrl_pkg::*;
#(
  parameter int              OPW     = DEF_OPW,
  parameter logic [OPW-1:0]  OP_LDI  = OPW'(DEF_OP_LDI),
  parameter logic [OPW-1:0]  OP_CMP  = OPW'(DEF_OP_CMP),
  parameter logic [OPW-1:0]  OP_BRU  = OPW'(DEF_OP_BRU),
  parameter logic [OPW-1:0]  OP_BRC  = OPW'(DEF_OP_BRC),
  parameter logic [OPW-1:0]  OP_LD   = OPW'(DEF_OP_LD),
  parameter logic [OPW-1:0]  OP_ST   = OPW'(DEF_OP_ST),
  parameter logic [OPW-1:0]  OP_HALT = OPW'(DEF_OP_HALT)
) (
  input  logic [OPW-1:0] i_opcode,
  output op_class_t      o_class
);

  always_comb begin
    o_class = C_ALU;
    if      (i_opcode == OP_LDI)  o_class = C_LDI;
    else if (i_opcode == OP_CMP)  o_class = C_CMP;
    else if (i_opcode == OP_BRU)  o_class = C_BRU;
    else if (i_opcode == OP_BRC)  o_class = C_BRC;
    else if (i_opcode == OP_LD)   o_class = C_LD;
    else if (i_opcode == OP_ST)   o_class = C_ST;
    else if (i_opcode == OP_HALT) o_class = C_HALT;
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with start/done handshake.
// Optional memory-timeout watchdog enabled by defining CTRL_MEM_TIMEOUT_EN.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int              OPW         = DEF_OPW,
  parameter int              IW          = DEF_IW,
  parameter logic [OPW-1:0]  OP_LDI      = OPW'(DEF_OP_LDI),
  parameter logic [OPW-1:0]  OP_CMP      = OPW'(DEF_OP_CMP),
  parameter logic [OPW-1:0]  OP_BRU      = OPW'(DEF_OP_BRU),
  parameter logic [OPW-1:0]  OP_BRC      = OPW'(DEF_OP_BRC),
  parameter logic [OPW-1:0]  OP_LD       = OPW'(DEF_OP_LD),
  parameter logic [OPW-1:0]  OP_ST       = OPW'(DEF_OP_ST),
  parameter logic [OPW-1:0]  OP_HALT     = OPW'(DEF_OP_HALT),
  parameter int              MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [IW-1:0] i_instr,
  input  logic          i_br_cond,
  input  logic          i_mem_ack,
  output logic          o_ir_load,
  output logic          o_pc_en,
  output logic          o_branch,
  output logic          o_ld_immed,
  output logic          o_mem_to_reg,
  output logic          o_mem_req,
  output logic          o_mem_write,
  output logic          o_reg_write,
  output logic          o_done,
  output logic          o_err
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [OPW-1:0] r_opcode;
  op_class_t      w_class;
  ctrl_sig_t      w_ctrl;
  logic           w_to_hit;
  logic           w_unused_instr;

  assign w_unused_instr = ^i_instr[IW-OPW-1:0];

  ctrl_op_class #(
    .OPW     (OPW),
    .OP_LDI  (OP_LDI),
    .OP_CMP  (OP_CMP),
    .OP_BRU  (OP_BRU),
    .OP_BRC  (OP_BRC),
    .OP_LD   (OP_LD),
    .OP_ST   (OP_ST),
    .OP_HALT (OP_HALT)
  ) u_op_class (
    .i_opcode (r_opcode),
    .o_class  (w_class)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_opcode <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_FETCH) r_opcode <= i_instr[IW-1 -: OPW];
    end
  end

  // branch in EXEC and store pc_en in MEM follow br_cond / mem_ack in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl      = '0;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_FETCH;
      S_FETCH: begin
        w_ctrl.ir_load = 1'b1;
        w_state_nxt    = S_DECODE;
      end
      S_DECODE: begin
        if (w_class == C_HALT)                        w_state_nxt = S_HALT;
        else if (w_class == C_LD || w_class == C_ST)  w_state_nxt = S_MEM;
        else                                          w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        case (w_class)
          C_BRU: begin
            w_ctrl.branch = 1'b1;
            w_ctrl.pc_en  = 1'b1;
            w_state_nxt   = S_FETCH;
          end
          C_BRC: begin
            w_ctrl.branch = i_br_cond;
            w_ctrl.pc_en  = 1'b1;
            w_state_nxt   = S_FETCH;
          end
          C_CMP: begin
            w_ctrl.pc_en = 1'b1;
            w_state_nxt  = S_FETCH;
          end
          C_LDI: begin
            w_ctrl.ld_immed = 1'b1;
            w_state_nxt     = S_WB;
          end
          default: w_state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        w_ctrl.mem_req   = 1'b1;
        w_ctrl.mem_write = (w_class == C_ST);
        if (i_mem_ack) begin
          if (w_class == C_ST) begin
            w_ctrl.pc_en = 1'b1;
            w_state_nxt  = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end else if (w_to_hit) begin
          w_state_nxt = S_HALT;
        end
      end
      S_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.pc_en      = 1'b1;
        w_ctrl.mem_to_reg = (w_class == C_LD);
        w_ctrl.ld_immed   = (w_class == C_LDI);
        w_state_nxt       = S_FETCH;
      end
      S_HALT: if (i_start) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_err;

  assign w_to_hit = (r_state == S_MEM) && !i_mem_ack &&
                    (r_to_cnt == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state != S_MEM)  r_to_cnt <= '0;
      else if (!i_mem_ack)   r_to_cnt <= r_to_cnt + 1'b1;
      if (w_to_hit)
        r_err <= 1'b1;
      else if (i_start && (r_state == S_IDLE || r_state == S_HALT))
        r_err <= 1'b0;
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (MEM_TIMEOUT == 0);
  assign w_to_hit         = 1'b0;
  assign o_err            = 1'b0;
`endif

  assign o_ir_load    = w_ctrl.ir_load;
  assign o_pc_en      = w_ctrl.pc_en;
  assign o_branch     = w_ctrl.branch;
  assign o_ld_immed   = w_ctrl.ld_immed;
  assign o_mem_to_reg = w_ctrl.mem_to_reg;
  assign o_mem_req    = w_ctrl.mem_req;
  assign o_mem_write  = w_ctrl.mem_write;
  assign o_reg_write  = w_ctrl.reg_write;
  assign o_done       = (r_state == S_HALT);

endmodule
